// File: rtl/rotate_right_iter.sv
// Iterative rotate-right unit: rotates an operand right by 0..WIDTH-1 places, one bit per clock.
// Latency: done pulses b+1 cycles after the accepted start edge; back in IDLE after b+2 edges.
// Backpressure: start is only accepted while ready=1; requests while busy are dropped, not queued.
module rotate_right_iter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] data_rot;

  // One-place rotate right of the working register.
  assign data_rot = {data[0], data[WIDTH-1:1]};

  // Control FSM plus working and result registers; out is only written on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= '0;
      cnt   <= '0;
      out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data <= a;
            cnt  <= b;
            if (b == '0) begin
              // Zero amount is the identity: publish the operand directly.
              out   <= a;
              state <= DONE;
            end else begin
              state <= ROTATE;
            end
          end
        end
        ROTATE: begin
          data <= data_rot;
          cnt  <= cnt - AMT_W'(1);
          // Last step: publish the final rotation in the same edge.
          if (cnt == AMT_W'(1)) begin
            out   <= data_rot;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decoded purely from registered state.
  assign ready = (state == IDLE);
  assign busy  = (state == ROTATE) || (state == DONE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_rotate_right_iter.sv
// Directed and swept bench for rotate_right_iter.
// Checks reset values, result values, done latency, collisions and reset abort.
// Inputs driven 1ns after rising edges; outputs sampled at the same point.
module tb_rotate_right_iter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [2:0] b;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] out;

  int n_vec  = 0;
  int n_miss = 0;

  rotate_right_iter #(.WIDTH(8), .AMT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ror_ref(input logic [7:0] x, input int s);
    logic [15:0] t;
    t = {x, x} >> s;
    return t[7:0];
  endfunction

  function automatic logic [7:0] rol_ref(input logic [7:0] x, input int s);
    logic [15:0] t;
    t = {x, x} << s;
    return t[15:8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for ready, issue a one-cycle start, then follow the operation to DONE.
  // lat = edges after E0 until done is seen; ready_after = ready one edge later.
  task automatic run_op(input logic [7:0] av, input logic [2:0] bv,
                        output logic [7:0] res, output int lat, output logic ready_after);
    int guard;
    guard = 0;
    while (!ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!ready) check("ready_wait", 0, 1);
    start = 1'b1;
    a     = av;
    b     = bv;
    tick();                  // E0
    start = 1'b0;
    a     = ~av;             // operands may change freely after acceptance
    b     = ~bv;
    lat   = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    res = out;
    tick();
    ready_after = ready;
  endtask

  logic [7:0] res;
  int         lat;
  logic       rdy;
  int         ndone;
  int         nbusy;
  logic [7:0] got_out;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 3'd0;
    #23;
    check("rst_ready", ready, 1);
    check("rst_busy",  busy,  0);
    check("rst_done",  done,  0);
    check("rst_out",   out,   8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic: B4 >> 3 -> 96, done after E3, ready after E4, out held.
    run_op(8'hB4, 3'd3, res, lat, rdy);
    check("basic_out",   res, 8'h96);
    check("basic_lat",   lat, 3);
    check("basic_ready", rdy, 1);
    tick(); tick();
    check("basic_hold",  out, 8'h96);

    // Zero amount: identity, done right after E0, one busy cycle (DONE only).
    start = 1'b1; a = 8'hA5; b = 3'd0;
    tick();
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_out",  out,  8'hA5);
    nbusy = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy) nbusy++;
      tick();
    end
    check("zero_busy_cycles", nbusy, 1);

    // Max amount: 01 >> 7 -> 02, done after E7.
    run_op(8'h01, 3'd7, res, lat, rdy);
    check("max_out",   res, 8'h02);
    check("max_lat",   lat, 7);
    check("max_ready", rdy, 1);

    // Inverse: A5 is B4 rotated left by 3; rotating it right by 3 restores B4.
    run_op(8'hA5, 3'd3, res, lat, rdy);
    check("inv_b4", res, 8'hB4);

    // Busy collision: second start during ROTATE is ignored entirely.
    start = 1'b1; a = 8'hF0; b = 3'd5;
    tick();                              // E0
    start = 1'b0;
    got_out = out;
    tick();                              // E1
    start = 1'b1; a = 8'h0F; b = 3'd1;
    tick();                              // E2, ignored
    start = 1'b0;
    check("coll_out_stable", out, got_out);
    ndone = 0;
    res   = 8'h00;
    for (int i = 0; i < 14; i++) begin
      if (done) begin
        ndone++;
        res = out;
      end
      tick();
    end
    check("coll_out",   res,   8'h87);
    check("coll_ndone", ndone, 1);
    check("coll_final", out,   8'h87);

    // Reset mid-operation: abort after E2, no done afterwards.
    start = 1'b1; a = 8'hC3; b = 3'd6;
    tick();                              // E0
    start = 1'b0;
    tick();                              // E1
    tick();                              // E2
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out",   out,   8'h00);
    check("abort_done",  done,  0);
    check("abort_ready", ready, 1);
    check("abort_busy",  busy,  0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(8'h81, 3'd1, res, lat, rdy);
    check("post_abort_out", res, 8'hC0);
    check("post_abort_lat", lat, 1);

    // Held start: accepted once per IDLE visit, b=2 -> 4-edge period.
    start = 1'b1; a = 8'h03; b = 3'd2;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    start = 1'b0;
    check("held_ndone", ndone, 3);
    check("held_out",   out,   8'hC0);
    for (int i = 0; i < 4; i++) tick();

    // Exhaustive sweep against {a,a}>>b, with latency.
    for (int av = 0; av < 256; av++) begin
      for (int bv = 0; bv < 8; bv++) begin
        run_op(av[7:0], bv[2:0], res, lat, rdy);
        check($sformatf("sweep_%02h_%0d", av, bv), res, ror_ref(av[7:0], bv));
        check($sformatf("sweep_lat_%02h_%0d", av, bv), lat, bv);
      end
    end

    // Inverse sweep: rotate-right of a left-rotated value recovers the operand.
    for (int av = 0; av < 256; av++) begin
      for (int bv = 0; bv < 8; bv++) begin
        run_op(rol_ref(av[7:0], bv), bv[2:0], res, lat, rdy);
        check($sformatf("inv_%02h_%0d", av, bv), res, av);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
